ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
- Instruction-fetch sequencer for the single-cycle-read instruction memory (512 x 32-bit, word-indexed by addr[31:2], combinational read).
- Owns the program counter, drives the memory address, and captures {pc, word} into a 2-entry prefetch buffer.
- Presents instructions to decode over a valid/ready handshake; accepts branch/jump redirects and flushes the buffer.
- Stops on an out-of-range fetch until redirected.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- IMEM_DEPTH, 512: number of words in instruction memory; a fetch is out of range when pc[31:2] >= IMEM_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; equals the PC register.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- fetch_en  in  1  1 = fetching allowed; 0 = hold PC, no new pushes, buffer still drains.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target byte address.
- inst_valid  out  1  buffer head valid.
- inst_ready  in  1  decode accepts head.
- inst  out  32  head instruction word.
- inst_pc  out  32  head instruction address.
- inst_err  out  1  head entry is an out-of-range fetch (inst forced to 0).
- halted  out  1  controller is in HALT_ERR.
- retired_cnt  out  32  count of accepted handshakes (inst_valid & inst_ready); wraps 2^32-1 -> 0.

Behaviour:
- Reset (asynchronous, immediate):
  - pc = RESET_PC; buffer empty (count = 0); state = RUN; retired_cnt = 0.
  - Outputs: inst_valid = 0, inst = 0, inst_pc = 0, inst_err = 0, halted = 0, imem_addr = RESET_PC.
  - Reset asserted mid-operation discards all buffered entries and any pending redirect.
- Buffer: 2-entry FIFO of {pc[31:0], word[31:0], err}, first-word fall-through.
  - inst/inst_pc/inst_err show the head entry; they are 0 when empty.
  - pop = inst_valid & inst_ready.
- States: RUN, HALT_ERR.
- Push condition (RUN only): fetch_en & !redirect_valid & (count < 2, or count == 2 with a pop this cycle).
  - On push: entry = {pc, in_range ? imem_data : 0, !in_range}, where in_range = (pc[31:2] < IMEM_DEPTH).
  - If the pushed entry is in range: pc <= pc + 4 (32-bit wrap).
  - If the pushed entry is out of range: pc holds and state <= HALT_ERR.
- Latency: instruction at pc is visible on inst the cycle after the push edge. With inst_ready held 1 and no redirect, one instruction is delivered per cycle (full throughput).
- Simultaneous push and pop: count is unchanged; both occur.
- Full (count == 2) and no pop: no push, pc holds.
- HALT_ERR:
  - No pushes; halted = 1; buffer still drains normally.
  - Leaves only on redirect_valid.
  - fetch_en has no effect in this state.
- Redirect (highest priority, any state):
  - At the clock edge: buffer cleared (count <= 0); pc <= {redirect_pc[31:2], 2'b00}; state <= RUN; no push that cycle.
  - A pop coincident with a redirect still counts toward retired_cnt.
  - First post-redirect instruction is valid 2 cycles after redirect_valid is sampled (redirect edge, then push edge).
- Misaligned redirect_pc: the low 2 bits are silently cleared; no error is raised.
- pc + 4 wrap from 32'hFFFF_FFFC to 0 is permitted; the wrapped address is treated as an ordinary fetch and range-checked.
- imem_addr is driven straight from the pc register; no combinational path from any input to imem_addr.

Test Plan:
- Reset then run: rst pulse, fetch_en = 1, inst_ready = 1, memory word k = 32'h1000_0000 + k -> first inst_valid one cycle after reset release, inst_pc = 0, 4, 8, ... on consecutive cycles, inst = 32'h1000_0000, 32'h1000_0001, ...; retired_cnt = 5 after 5 handshakes.
- Backpressure: inst_ready = 0 for 4 cycles -> buffer holds pc 0 and 4, imem_addr stays 8, inst_valid = 1 with inst_pc = 0 held stable; ready = 1 -> pc 0, 4, 8 delivered on back-to-back cycles.
- Redirect flush: with buffer holding pc 0x10 and 0x14, assert redirect_valid with redirect_pc = 0x42 -> next cycle inst_valid = 0 and imem_addr = 0x40; following cycle inst_pc = 0x40.
- Out of range: redirect_pc = 0x7FC (word 511), run -> pc 0x7FC delivered with inst_err = 0, then pc 0x800 delivered with inst_err = 1 and inst = 0; halted = 1; imem_addr stays 0x800; redirect_pc = 0 -> halted = 0 and fetch resumes at pc 0.
- fetch_en gating: fetch_en = 0 for 3 cycles with ready = 1 -> buffer drains to inst_valid = 0 and pc holds; fetch_en = 1 -> resumes at the held pc.
- Async reset mid-stream: assert rst between clock edges with the buffer full -> inst_valid = 0, imem_addr = RESET_PC, and retired_cnt = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads imem, and queues {pc, word, err} in a 2-entry fall-through buffer for decode.
// Latency: an instruction is visible on inst the cycle after its push edge; a redirect costs 2 cycles to the first new instruction.
// Backpressure: inst_ready low stalls pops; when the buffer is full and nothing pops, the PC holds and no fetch is issued.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err,
    output logic        halted,
    output logic [31:0] retired_cnt
);

    typedef enum logic {RUN, HALT_ERR} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic        err;
    } entry_t;

    localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

    state_t      state;
    logic [31:0] pc;
    entry_t      slot0;   // head of the buffer
    entry_t      slot1;   // second entry, valid only when count == 2
    logic [1:0]  count;

    logic        in_range;
    logic        pop;
    logic        push;
    entry_t      new_entry;

    // Fetch decision for this cycle: range check, handshake and push qualification.
    always_comb begin
        in_range       = (pc[31:2] < DEPTH_W);
        new_entry.pc   = pc;
        new_entry.word = in_range ? imem_data : 32'h0;
        new_entry.err  = !in_range;
        pop            = (count != 2'd0) && inst_ready;
        push           = (state == RUN) && fetch_en && !redirect_valid &&
                         ((count != 2'd2) || pop);
    end

    // Head-of-buffer view for decode; outputs read zero whenever the buffer is empty.
    assign imem_addr  = pc;
    assign inst_valid = (count != 2'd0);
    assign inst       = inst_valid ? slot0.word : 32'h0;
    assign inst_pc    = inst_valid ? slot0.pc   : 32'h0;
    assign inst_err   = inst_valid ? slot0.err  : 1'b0;
    assign halted     = (state == HALT_ERR);

    // Controller state: PC, halt FSM, buffer contents and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            slot0       <= '0;
            slot1       <= '0;
            count       <= 2'd0;
            retired_cnt <= 32'h0;
        end else begin
            // A pop coincident with a redirect was still accepted by decode.
            if (pop) begin
                retired_cnt <= retired_cnt + 32'd1;
            end

            if (redirect_valid) begin
                count <= 2'd0;
                pc    <= redirect_pc & ~32'h3;
                state <= RUN;
            end else begin
                // An out-of-range fetch is queued as an error entry and parks the PC on it.
                if (push) begin
                    if (in_range) begin
                        pc <= pc + 32'd4;
                    end else begin
                        state <= HALT_ERR;
                    end
                end

                case ({push, pop})
                    2'b11: begin
                        if (count == 2'd1) begin
                            slot0 <= new_entry;
                        end else begin
                            slot0 <= slot1;
                            slot1 <= new_entry;
                        end
                    end
                    2'b01: begin
                        slot0 <= slot1;
                        count <= count - 2'd1;
                    end
                    2'b10: begin
                        if (count == 2'd0) begin
                            slot0 <= new_entry;
                        end else begin
                            slot1 <= new_entry;
                        end
                        count <= count + 2'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a behavioural imem, a scoreboard of expected deliveries, and point checks of PC/halt/counter.
// Latency: inputs change and outputs are sampled on the falling edge, half a cycle away from the active edge.
// Backpressure: inst_ready is driven by the bench to exercise stall, drain and flush cases.
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        halted;
    logic [31:0] retired_cnt;

    int total = 0;
    int bad   = 0;

    // Expected deliveries as {pc, word, err}.
    logic [64:0] sb_q[$];

    ifetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (512)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .halted         (halted),
        .retired_cnt    (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word k holds 32'h1000_0000 + k; beyond the array the bus carries junk.
    function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
        return 32'h1000_0000 + {2'b00, byte_addr[31:2]};
    endfunction

    assign imem_data = (imem_addr[31:2] < 30'd512) ? word_at(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ok(input logic [31:0] a);
        sb_q.push_back({a, word_at(a), 1'b0});
    endtask

    // One cycle: if a handshake is set up for the coming edge, score the head entry, then move to the next falling edge.
    task automatic cyc();
        logic [64:0] exp;
        if (inst_valid && inst_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", {inst_pc, inst, inst_err}, 65'h0);
            end else begin
                exp = sb_q.pop_front();
                chk("delivered", {inst_pc, inst, inst_err}, exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        #2;
        chk("rst_valid",   {64'h0, inst_valid}, 65'h0);
        chk("rst_inst",    {33'h0, inst}, 65'h0);
        chk("rst_inst_pc", {33'h0, inst_pc}, 65'h0);
        chk("rst_err",     {64'h0, inst_err}, 65'h0);
        chk("rst_halted",  {64'h0, halted}, 65'h0);
        chk("rst_addr",    {33'h0, imem_addr}, 65'h0);
        chk("rst_retired", {33'h0, retired_cnt}, 65'h0);

        // Reset then run at full throughput
        @(negedge clk);
        rst        = 1'b0;
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) expect_ok(32'(k * 4));
        cyc();
        chk("first_valid", {64'h0, inst_valid}, 65'h1);
        cycles(5);
        chk("retired_5", {33'h0, retired_cnt}, 65'd5);
        chk("sb_empty_run", 65'(sb_q.size()), 65'h0);

        // Backpressure: restart at 0 with decode stalled
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        cycles(2);
        chk("bp_head_pc_mid", {33'h0, inst_pc}, 65'h0);
        cycles(2);
        chk("bp_valid",   {64'h0, inst_valid}, 65'h1);
        chk("bp_head_pc", {33'h0, inst_pc}, 65'h0);
        chk("bp_inst",    {33'h0, inst}, {33'h0, 32'h1000_0000});
        chk("bp_addr",    {33'h0, imem_addr}, 65'h8);
        inst_ready = 1'b1;
        expect_ok(32'h0);
        expect_ok(32'h4);
        expect_ok(32'h8);
        cycles(3);
        chk("sb_empty_bp", 65'(sb_q.size()), 65'h0);

        // Redirect flush with buffer holding 0x10 and 0x14
        expect_ok(32'hC);
        cyc();
        inst_ready = 1'b0;
        chk("fl_head_pc", {33'h0, inst_pc}, 65'h10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        cyc();
        redirect_valid = 1'b0;
        chk("fl_valid", {64'h0, inst_valid}, 65'h0);
        chk("fl_addr",  {33'h0, imem_addr}, 65'h40);
        cyc();
        chk("fl_new_valid", {64'h0, inst_valid}, 65'h1);
        chk("fl_new_pc",    {33'h0, inst_pc}, 65'h40);
        chk("fl_new_inst",  {33'h0, inst}, {33'h0, 32'h1000_0010});
        chk("retired_9",    {33'h0, retired_cnt}, 65'd9);

        // Redirect to the last word with a coincident pop, then run off the end of memory
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h7FC;
        expect_ok(32'h40);
        cyc();
        redirect_valid = 1'b0;
        chk("retired_10", {33'h0, retired_cnt}, 65'd10);
        chk("oor_addr0",  {33'h0, imem_addr}, 65'h7FC);
        expect_ok(32'h7FC);
        sb_q.push_back({32'h800, 32'h0, 1'b1});
        cycles(2);
        chk("oor_halted", {64'h0, halted}, 65'h1);
        chk("oor_err",    {64'h0, inst_err}, 65'h1);
        cycles(3);
        chk("halt_valid", {64'h0, inst_valid}, 65'h0);
        chk("halt_still", {64'h0, halted}, 65'h1);
        chk("halt_addr",  {33'h0, imem_addr}, 65'h800);
        chk("sb_empty_oor", 65'(sb_q.size()), 65'h0);

        // Leave HALT_ERR via redirect to 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        chk("unhalt",      {64'h0, halted}, 65'h0);
        chk("unhalt_addr", {33'h0, imem_addr}, 65'h0);
        expect_ok(32'h0);
        expect_ok(32'h4);
        cycles(2);

        // fetch_en gating: drain with fetch disabled, resume at held pc
        fetch_en = 1'b0;
        cycles(3);
        chk("gate_valid", {64'h0, inst_valid}, 65'h0);
        chk("gate_addr",  {33'h0, imem_addr}, 65'h8);
        fetch_en = 1'b1;
        expect_ok(32'h8);
        expect_ok(32'hC);
        cyc();
        chk("resume_pc", {33'h0, inst_pc}, 65'h8);
        cycles(2);
        chk("sb_empty_gate", 65'(sb_q.size()), 65'h0);
        chk("retired_16",    {33'h0, retired_cnt}, 65'd16);

        // Async reset with the buffer full, between clock edges
        inst_ready = 1'b0;
        cycles(2);
        chk("pre_rst_pc",   {33'h0, inst_pc}, 65'h10);
        chk("pre_rst_addr", {33'h0, imem_addr}, 65'h18);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid",   {64'h0, inst_valid}, 65'h0);
        chk("arst_addr",    {33'h0, imem_addr}, 65'h0);
        chk("arst_retired", {33'h0, retired_cnt}, 65'h0);
        chk("arst_inst_pc", {33'h0, inst_pc}, 65'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("post_rst_pc", {33'h0, inst_pc}, 65'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
